// File: rtl/morse_symbol_classifier.sv
// Morse key classifier: turns timed key marks/spaces into dot/dash letter patterns.
// Optional macro MORSE_DEBOUNCE_EN adds a two-tick stability filter on the synchronised key.
module morse_symbol_classifier #(
   parameter int DASH_TICKS = 3,
   parameter int GAP_TICKS  = 3,
   parameter int MAX_SYMS   = 5,
   parameter int CNT_W      = 4
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                clk_div,
   input  logic                key_in,
   output logic                sym_valid,
   output logic [MAX_SYMS-1:0] sym_bits,
   output logic [2:0]          sym_len,
   output logic                overflow
);

   typedef enum logic [1:0] {S_IDLE, S_MARK, S_SPACE, S_EMIT} state_t;

   localparam logic [CNT_W-1:0] DASH_C  = CNT_W'(DASH_TICKS);
   localparam logic [CNT_W-1:0] GAP_C   = CNT_W'(GAP_TICKS);
   localparam logic [2:0]       MAX_LEN = 3'(MAX_SYMS);

   state_t              state_q;
   logic                clk_div_q;
   logic                key_s1_q, key_s2_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    cnt_d;
   logic [2:0]          len_q;
   logic [MAX_SYMS-1:0] pattern_q;
   logic                tick;
   logic                key;

   assign tick  = clk_div & ~clk_div_q;
   assign cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

   // NOTE: every register below uses non-blocking assignment so all state
   // updates on one edge see the pre-edge values, regardless of block order.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         clk_div_q <= 1'b0;
         key_s1_q  <= 1'b0;
         key_s2_q  <= 1'b0;
      end else begin
         clk_div_q <= clk_div;
         key_s1_q  <= key_in;
         key_s2_q  <= key_s1_q;
      end
   end

`ifdef MORSE_DEBOUNCE_EN
   logic key_smp_q, key_db_q;

   // A level is accepted only when two consecutive tick samples agree.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         key_smp_q <= 1'b0;
         key_db_q  <= 1'b0;
      end else if (tick) begin
         key_smp_q <= key_s2_q;
         if (key_s2_q == key_smp_q) key_db_q <= key_s2_q;
      end
   end

   assign key = key_db_q;
`else
   assign key = key_s2_q;
`endif

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         len_q     <= '0;
         pattern_q <= '0;
         sym_valid <= 1'b0;
         sym_bits  <= '0;
         sym_len   <= '0;
         overflow  <= 1'b0;
      end else begin
         sym_valid <= 1'b0;
         case (state_q)
            S_IDLE: begin
               cnt_q <= '0;
               if (key) state_q <= S_MARK;
            end
            S_MARK: begin
               if (!key) begin
                  // Zero-tick marks fall below DASH_C and become dots.
                  if (len_q == MAX_LEN) begin
                     overflow <= 1'b1;
                  end else begin
                     pattern_q[len_q] <= (cnt_q >= DASH_C);
                     len_q            <= len_q + 3'd1;
                  end
                  cnt_q   <= '0;
                  state_q <= S_SPACE;
               end else if (tick) begin
                  cnt_q <= cnt_d;
               end
            end
            S_SPACE: begin
               if (key) begin
                  cnt_q   <= '0;
                  state_q <= S_MARK;
               end else if (cnt_q >= GAP_C) begin
                  sym_valid <= 1'b1;
                  sym_bits  <= pattern_q;
                  sym_len   <= len_q;
                  state_q   <= S_EMIT;
               end else if (tick) begin
                  cnt_q <= cnt_d;
               end
            end
            S_EMIT: begin
               pattern_q <= '0;
               len_q     <= '0;
               cnt_q     <= '0;
               state_q   <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_morse_symbol_classifier.sv
// Directed bench for morse_symbol_classifier: letters E, T, A, overflow, reset, glitch.
// Expectations target the default build; the glitch step also covers MORSE_DEBOUNCE_EN.
module tb_morse_symbol_classifier;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       clk_div = 1'b0;
   logic       key_in = 1'b0;
   logic       sym_valid;
   logic [4:0] sym_bits;
   logic [2:0] sym_len;
   logic       overflow;

   int checks = 0;
   int failures = 0;
   int pulses = 0;
   int pulses_base = 0;
   logic prev_valid = 1'b0;
   logic long_pulse = 1'b0;
   logic [2:0] div_cnt = 3'd0;

   morse_symbol_classifier #(
      .DASH_TICKS(3), .GAP_TICKS(3), .MAX_SYMS(5), .CNT_W(4)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .clk_div(clk_div), .key_in(key_in),
      .sym_valid(sym_valid), .sym_bits(sym_bits), .sym_len(sym_len),
      .overflow(overflow)
   );

   always #5 CLK = ~CLK;

   // Timebase: clk_div rises once every 8 CLK cycles, changing on the falling edge.
   always @(negedge CLK) begin
      div_cnt = div_cnt + 3'd1;
      clk_div = div_cnt[2];
   end

   always @(negedge CLK) begin
      if (sym_valid) begin
         pulses = pulses + 1;
         if (prev_valid) long_pulse = 1'b1;
      end
      prev_valid = sym_valid;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) @(posedge clk_div);
   endtask

   task automatic mark(input int n);
      key_in = 1'b1;
      wait_ticks(n);
      key_in = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge CLK);
      #1;
      check("rst_valid",    32'(sym_valid), 32'd0);
      check("rst_bits",     32'(sym_bits),  32'd0);
      check("rst_len",      32'(sym_len),   32'd0);
      check("rst_overflow", 32'(overflow),  32'd0);
      @(negedge CLK);
      RST_N = 1'b1;
      wait_ticks(2);

      // E: one dot
      pulses_base = pulses;
      mark(1); wait_ticks(4); repeat (4) @(negedge CLK);
      check("e_pulses", 32'(pulses - pulses_base), 32'd1);
      check("e_bits",   32'(sym_bits), 32'b00000);
      check("e_len",    32'(sym_len),  32'd1);
      check("e_valid_low", 32'(sym_valid), 32'd0);

      // T: one dash
      pulses_base = pulses;
      mark(4); wait_ticks(4); repeat (4) @(negedge CLK);
      check("t_pulses", 32'(pulses - pulses_base), 32'd1);
      check("t_bits",   32'(sym_bits), 32'b00001);
      check("t_len",    32'(sym_len),  32'd1);

      // A: dot, dash
      pulses_base = pulses;
      mark(1); wait_ticks(1);
      mark(4); wait_ticks(4); repeat (4) @(negedge CLK);
      check("a_pulses", 32'(pulses - pulses_base), 32'd1);
      check("a_bits",   32'(sym_bits), 32'b00010);
      check("a_len",    32'(sym_len),  32'd2);
      check("a_overflow", 32'(overflow), 32'd0);

      // Six dots: sixth element is discarded and overflow sets
      pulses_base = pulses;
      for (int i = 0; i < 6; i++) begin
         mark(1); wait_ticks(1);
      end
      wait_ticks(3); repeat (4) @(negedge CLK);
      check("ov_pulses",   32'(pulses - pulses_base), 32'd1);
      check("ov_bits",     32'(sym_bits), 32'b00000);
      check("ov_len",      32'(sym_len),  32'd5);
      check("ov_overflow", 32'(overflow), 32'd1);

      // Next letter keeps overflow sticky
      pulses_base = pulses;
      mark(4); wait_ticks(4); repeat (4) @(negedge CLK);
      check("ov2_pulses",   32'(pulses - pulses_base), 32'd1);
      check("ov2_bits",     32'(sym_bits), 32'b00001);
      check("ov2_overflow", 32'(overflow), 32'd1);

      // Reset mid-letter after two marks
      pulses_base = pulses;
      mark(4); wait_ticks(1);
      mark(1); repeat (3) @(negedge CLK);
      RST_N = 1'b0;
      #1;
      check("mid_rst_valid",    32'(sym_valid), 32'd0);
      check("mid_rst_bits",     32'(sym_bits),  32'd0);
      check("mid_rst_len",      32'(sym_len),   32'd0);
      check("mid_rst_overflow", 32'(overflow),  32'd0);
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      wait_ticks(5);
      check("post_rst_pulses", 32'(pulses - pulses_base), 32'd0);
      check("post_rst_len",    32'(sym_len),  32'd0);
      check("post_rst_ov",     32'(overflow), 32'd0);

      // One-CLK key glitch between ticks
      pulses_base = pulses;
      wait_ticks(1);
      repeat (3) @(negedge CLK);
      key_in = 1'b1;
      @(negedge CLK);
      key_in = 1'b0;
      wait_ticks(5);
`ifdef MORSE_DEBOUNCE_EN
      check("glitch_pulses", 32'(pulses - pulses_base), 32'd0);
      check("glitch_len",    32'(sym_len), 32'd0);
`else
      check("glitch_pulses", 32'(pulses - pulses_base), 32'd1);
      check("glitch_len",    32'(sym_len),  32'd1);
      check("glitch_bits",   32'(sym_bits), 32'b00000);
`endif

      check("valid_one_cycle", 32'(long_pulse), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/morse_symbol_classifier.md
MORSE_SYMBOL_CLASSIFIER -- requirements
Module: morse_symbol_classifier

Interface
REQ-001 SHALL have parameter DASH_TICKS, default 3: minimum mark length, in ticks, classified as dash.
REQ-002 SHALL have parameter GAP_TICKS, default 3: space length, in ticks, that ends a letter.
REQ-003 SHALL have parameter MAX_SYMS, default 5: maximum dots and dashes per letter.
REQ-004 SHALL have parameter CNT_W, default 4: duration counter width.
REQ-005 SHALL have port CLK, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-006 SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port clk_div, input, 1 bit: divided toggling timebase from the upstream comparator, synchronous to CLK.
REQ-008 SHALL have port key_in, input, 1 bit: raw Morse key, 1 = pressed, asynchronous.
REQ-009 SHALL have port sym_valid, output, 1 bit: one-CLK pulse when a letter completes.
REQ-010 SHALL have port sym_bits, output, MAX_SYMS bits: letter pattern, 1 = dash, first element in bit 0.
REQ-011 SHALL have port sym_len, output, 3 bits: number of valid elements in sym_bits.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag, set when a letter exceeds MAX_SYMS.

Function
REQ-013 SHALL generate internal tick as a one-CLK pulse on each rising edge of clk_div (registered previous value, 1-cycle detection latency).
REQ-014 SHALL synchronise key_in through two flops; key = second flop output.
REQ-015 SHALL implement states IDLE, MARK, SPACE, EMIT.
REQ-016 IDLE: key=1 -> MARK; cnt cleared.
REQ-017 MARK: each tick increments cnt, saturating at 2^CNT_W-1.
REQ-018 MARK: key=0 -> append element (dash if cnt>=DASH_TICKS, else dot), increment len, clear cnt, -> SPACE.
REQ-019 MARK: a mark of 0 ticks SHALL be classified as a dot.
REQ-020 Append with len already = MAX_SYMS SHALL discard the element, leave pattern/len unchanged and set overflow.
REQ-021 SPACE: each tick increments cnt (saturating); key=1 -> MARK with cnt cleared.
REQ-022 SPACE: when cnt reaches GAP_TICKS -> EMIT; key=1 and tick in the same cycle as the threshold SHALL go to MARK (key wins).
REQ-023 EMIT: lasts exactly one CLK; sym_valid=1; sym_bits/sym_len load the accumulated pattern in that cycle; internal pattern, len and cnt cleared; -> IDLE regardless of key.
REQ-024 sym_bits and sym_len SHALL hold their value until the next EMIT.
REQ-025 overflow SHALL remain set until reset.
REQ-026 Unused upper sym_bits positions (index >= sym_len) SHALL read 0.

Reset
REQ-027 RST_N=0 SHALL immediately force state IDLE; cnt, len, pattern, synchronisers and tick history = 0; sym_valid=0, sym_bits=0, sym_len=0, overflow=0.
REQ-028 Reset mid-letter SHALL discard the partial letter, with no sym_valid after release.
REQ-029 After RST_N deasserts, the first state change SHALL occur no earlier than the second CLK edge (synchroniser fill).

Configuration
REQ-030 Macro MORSE_DEBOUNCE_EN defined: the synchronised key SHALL be accepted as a new level only after being stable across 2 consecutive ticks; shorter glitches are ignored; adds up to 2 ticks of latency.
REQ-031 Macro MORSE_DEBOUNCE_EN undefined: the synchronised key SHALL drive the FSM directly, with no debounce logic present.

Verification
REQ-032 Key held 1 tick, released 4 ticks -> one sym_valid, sym_bits=00000, sym_len=1 ("E").
REQ-033 Key held 4 ticks, released 4 ticks -> sym_bits=00001, sym_len=1 ("T").
REQ-034 Key held 1 tick, 1-tick gap, held 4 ticks, 4-tick gap -> sym_bits=00010, sym_len=2 ("A"); exactly one sym_valid pulse.
REQ-035 Six dots with 1-tick gaps, then 4-tick gap -> sym_len=5, sym_bits=00000, overflow=1 and stays 1 after the next letter.
REQ-036 RST_N pulsed low after two marks in a letter -> all outputs 0 immediately; no sym_valid after release.
REQ-037 MORSE_DEBOUNCE_EN defined, 1-CLK key glitch between ticks -> no state change and no sym_valid; macro undefined, same glitch -> dot is emitted.
